axi_coeff_bank: RTL and testbench
=================================

AXI_COEFF_BANK -- requirements
Module: axi_coeff_bank

Interface
REQ-001 SHALL have parameter KSIZE, default 5: kernel edge length, legal range 3..7.
REQ-002 SHALL have parameter CW, default 16: signed coefficient width, legal range 2..32.
REQ-003 SHALL have parameter ADDR_BITS, default 8: AXI byte-address bits decoded.
REQ-004 Port clk, input, 1: sole clock for all logic.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Ports s_axi_awaddr[ADDR_BITS], s_axi_awvalid (in); s_axi_awready (out): AXI4-Lite write address channel.
REQ-007 Ports s_axi_wdata[32], s_axi_wstrb[4], s_axi_wvalid (in); s_axi_wready (out): write data channel.
REQ-008 Ports s_axi_bresp[2], s_axi_bvalid (out); s_axi_bready (in): write response channel.
REQ-009 Ports s_axi_araddr[ADDR_BITS], s_axi_arvalid (in); s_axi_arready (out): read address channel.
REQ-010 Ports s_axi_rdata[32], s_axi_rresp[2], s_axi_rvalid (out); s_axi_rready (in): read data channel.
REQ-011 Port frame_start, input, 1: single-cycle pulse marking the filter frame boundary.
REQ-012 Port coeff, output, KSIZE*KSIZE*CW: active bank, flat; coefficient (r,c) at slice index r*KSIZE+c.
REQ-013 Port coeff_update, output, 1: one-cycle pulse, active bank changed.

Function
REQ-014 Address map (word = addr[ADDR_BITS-1:2]): words 0..KSIZE*KSIZE-1 = shadow coefficients; word 62 = CTRL; word 63 = STATUS; all others unmapped.
REQ-015 Coefficient write SHALL update only the bytes enabled by wstrb that fall within bits [CW-1:0].
REQ-016 CTRL write: bit0=1 sets commit_pending; bit1=1 together with bit0 requests an immediate swap instead of waiting for frame_start.
REQ-017 Swap SHALL copy the entire shadow bank to the active bank in one cycle; coeff_update SHALL pulse the cycle after the swap.
REQ-018 Deferred swap SHALL occur on the first frame_start sampled while commit_pending=1; commit_pending SHALL clear in the same cycle.
REQ-019 Immediate swap SHALL occur the cycle after the CTRL write handshake completes.
REQ-020 A CTRL write completing in the same cycle as frame_start SHALL wait for the next frame_start.
REQ-021 A shadow write in the swap cycle SHALL land in shadow only; the active bank receives pre-write values.
REQ-022 STATUS (read-only): bit0 = commit_pending; bits[15:8] = swap count mod 256; all other bits 0.
REQ-023 Write FSM states IDLE, HAVE_ADDR, HAVE_DATA, RESP: AW and W SHALL be accepted independently in either order or together; awready/wready SHALL be high only while that channel is not latched and bvalid=0.
REQ-024 Write effect SHALL occur in the cycle both halves are held; bvalid SHALL rise the next cycle and hold until bready.
REQ-025 Read: arready=1 while rvalid=0; rdata/rvalid registered one cycle after the AR handshake and held until rready.
REQ-026 Coefficient reads SHALL return the shadow value sign-extended to 32 bits.
REQ-027 Unmapped or STATUS write: no state change, bresp=SLVERR (2'b10); unmapped read: rdata=0, rresp=SLVERR; all others OKAY.

Reset
REQ-028 On rst low: shadow, active, coeff, commit_pending, swap count = 0; all valid/ready outputs = 0; FSMs at IDLE.
REQ-029 Reset mid-transaction SHALL abandon it with no register update and no response.
REQ-030 awready, wready and arready SHALL go high the first cycle after rst deasserts.

Structure
REQ-031 Shared package axi_coeff_pkg SHALL hold the CTRL/STATUS word indices, bit positions, and the OKAY/SLVERR encodings.
REQ-032 Shadow and active storage plus swap logic SHALL live in sub-module coeff_bank_regs; the AXI FSMs stay in the top level.

Verification
REQ-033 Write 0x0000FFFF to word 0, then read word 0 -> rdata=0xFFFFFFFF, coeff slice 0 still 0.
REQ-034 Write word 6 = 0x1234, CTRL = 0x1 -> STATUS bit0=1; at the next frame_start, slice 6 = 0x1234 and coeff_update pulses once.
REQ-035 Send W two cycles before AW, then hold bready low for 3 cycles -> exactly one write, bvalid held, bresp=OKAY.
REQ-036 Write CTRL=0x3 with no frame_start -> swap the cycle after the handshake; STATUS[15:8] increments by 1.
REQ-037 Write to word 40 with KSIZE=5 -> SLVERR, no state change; read word 40 -> rdata=0, SLVERR.
REQ-038 Assert rst during HAVE_ADDR -> no bvalid; all coeff = 0; next write completes normally.

Source files
------------

// File: rtl/axi_coeff_pkg.sv
// Shared definitions for the AXI4-Lite coefficient bank.
// Holds the register-map word indices, the CTRL/STATUS bit positions and
// the AXI response encodings. It also holds the write/read FSM state
// encodings and a helper that assembles the STATUS word.
package axi_coeff_pkg;

   localparam int CTRL_WORD       = 62;
   localparam int STATUS_WORD     = 63;

   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_IMM_BIT    = 1;

   localparam int STATUS_PEND_BIT = 0;
   localparam int STATUS_CNT_LSB  = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'd0,
      WR_HAVE_ADDR = 2'd1,
      WR_HAVE_DATA = 2'd2,
      WR_RESP      = 2'd3
   } wr_state_e;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_VALID = 1'b1
   } rd_state_e;

   function automatic logic [31:0] make_status(input logic pending, input logic [7:0] count);
      logic [31:0] s;
      s = '0;
      s[STATUS_PEND_BIT] = pending;
      s[STATUS_CNT_LSB +: 8] = count;
      return s;
   endfunction

endpackage

// File: rtl/coeff_bank_regs.sv
// Shadow and active coefficient storage plus the bank swap logic.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wr_en/wr_idx        shadow write strobe and coefficient index
//   wr_data/wr_strb     AXI write data and byte strobes
//   commit_set          CTRL write with the commit bit set
//   imm_set             CTRL write requesting an immediate swap
//   frame_start         frame boundary pulse
//   rd_idx/rd_val       shadow read index and its sign-extended value
//   coeff               active bank, flat, coefficient k at [k*CW +: CW]
//   coeff_update        one-cycle pulse, the cycle after a swap
//   commit_pending      a swap is armed
//   swap_count          number of swaps, mod 256
module coeff_bank_regs
   import axi_coeff_pkg::*;
#(
   parameter int KSIZE = 5,
   parameter int CW    = 16,
   parameter int WW    = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WW-1:0]             wr_idx,
   input  logic [31:0]               wr_data,
   input  logic [3:0]                wr_strb,
   input  logic                      commit_set,
   input  logic                      imm_set,
   input  logic                      frame_start,
   input  logic [WW-1:0]             rd_idx,
   output logic [31:0]               rd_val,
   output logic [KSIZE*KSIZE*CW-1:0] coeff,
   output logic                      coeff_update,
   output logic                      commit_pending,
   output logic [7:0]                swap_count
);

   localparam int NCOEF = KSIZE * KSIZE;

   logic [CW-1:0] shadow [NCOEF];
   logic [CW-1:0] active [NCOEF];
   logic [CW-1:0] bit_mask;
   logic [CW-1:0] rd_raw;
   logic          imm_req;
   logic          swap;
   logic          unused_wr_bits;

   // Bytes of the 32-bit word above CW have no storage.
   assign unused_wr_bits = ^{wr_data, wr_strb};

   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < CW; i++) begin
         bit_mask[i] = wr_strb[i / 8];
      end
   end

   assign swap = imm_req | (frame_start & commit_pending);

   // Active takes the pre-write shadow contents when a shadow write
   // lands in the swap cycle (both use the old shadow value).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NCOEF; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NCOEF; k++) begin
            if (swap) begin
               active[k] <= shadow[k];
            end
            if (wr_en && (int'(wr_idx) == k)) begin
               shadow[k] <= (shadow[k] & ~bit_mask) | (wr_data[CW-1:0] & bit_mask);
            end
         end
      end
   end

   // A new commit wins over the clearing swap, so a CTRL write that
   // coincides with a swap stays armed for the next frame_start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_pending <= 1'b0;
         imm_req        <= 1'b0;
         swap_count     <= '0;
         coeff_update   <= 1'b0;
      end else begin
         coeff_update <= swap;
         imm_req      <= imm_set;
         if (swap) begin
            swap_count <= swap_count + 8'd1;
         end
         if (commit_set) begin
            commit_pending <= 1'b1;
         end else if (swap) begin
            commit_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_raw = '0;
      for (int k = 0; k < NCOEF; k++) begin
         if (int'(rd_idx) == k) begin
            rd_raw = shadow[k];
         end
      end
      rd_val = 32'(signed'(rd_raw));
   end

   for (genvar g = 0; g < NCOEF; g++) begin : g_coeff
      assign coeff[g*CW +: CW] = active[g];
   end

endmodule

// File: rtl/axi_coeff_bank.sv
// AXI4-Lite slave for a double-buffered KSIZE x KSIZE coefficient bank.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*           write address, write data, write response
//   s_axi_ar*/r*              read address, read data
//   frame_start               frame boundary pulse for deferred swaps
//   coeff                     active bank, flat
//   coeff_update              one-cycle pulse after a swap
//   dbg_wr_state/dbg_rd_state current write/read FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge.
// A ready never depends on the matching valid.
module axi_coeff_bank
   import axi_coeff_pkg::*;
#(
   parameter int KSIZE     = 5,
   parameter int CW        = 16,
   parameter int ADDR_BITS = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_BITS-1:0]      s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [31:0]               s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ADDR_BITS-1:0]      s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [31:0]               s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic                      frame_start,
   output logic [KSIZE*KSIZE*CW-1:0] coeff,
   output logic                      coeff_update,
   output logic [1:0]                dbg_wr_state,
   output logic                      dbg_rd_state
);

   localparam int WW    = ADDR_BITS - 2;
   localparam int NCOEF = KSIZE * KSIZE;

   wr_state_e            wr_state, wr_next;
   rd_state_e            rd_state, rd_next;
   logic                 out_en;
   logic [ADDR_BITS-1:0] aw_q;
   logic [31:0]          w_data_q;
   logic [3:0]           w_strb_q;
   logic [1:0]           bresp_q;
   logic [31:0]          rdata_q;
   logic [1:0]           rresp_q;
   logic                 aw_hs, w_hs, ar_hs, wr_fire;
   logic [ADDR_BITS-1:0] eff_addr;
   logic [31:0]          eff_data;
   logic [3:0]           eff_strb;
   logic [WW-1:0]        wr_word, rd_word;
   logic                 wr_is_coeff, wr_is_ctrl;
   logic                 rd_is_coeff, rd_is_ctrl, rd_is_status;
   logic                 commit_set, imm_set, commit_pending;
   logic [7:0]           swap_count;
   logic [31:0]          coeff_rd;
   logic                 unused_addr_lsbs;

   assign unused_addr_lsbs = ^{eff_addr[1:0], s_axi_araddr[1:0]};

   // Holds every ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_en <= 1'b0;
      else      out_en <= 1'b1;
   end

   assign aw_hs = s_axi_awvalid & s_axi_awready;
   assign w_hs  = s_axi_wvalid  & s_axi_wready;
   assign ar_hs = s_axi_arvalid & s_axi_arready;

   // ---------------- write FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_state <= WR_IDLE;
      else      wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) wr_next = WR_RESP;
            else if (aw_hs)    wr_next = WR_HAVE_ADDR;
            else if (w_hs)     wr_next = WR_HAVE_DATA;
         end
         WR_HAVE_ADDR: if (w_hs)         wr_next = WR_RESP;
         WR_HAVE_DATA: if (aw_hs)        wr_next = WR_RESP;
         WR_RESP:      if (s_axi_bready) wr_next = WR_IDLE;
         default:                        wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      wr_fire       = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            s_axi_awready = out_en;
            s_axi_wready  = out_en;
            wr_fire       = aw_hs & w_hs;
         end
         WR_HAVE_ADDR: begin
            s_axi_wready = out_en;
            wr_fire      = w_hs;
         end
         WR_HAVE_DATA: begin
            s_axi_awready = out_en;
            wr_fire       = aw_hs;
         end
         WR_RESP: s_axi_bvalid = 1'b1;
         default: ;
      endcase
   end

   assign s_axi_bresp  = bresp_q;
   assign dbg_wr_state = wr_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_q     <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
         bresp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_q <= s_axi_awaddr;
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         if (wr_fire) bresp_q <= (wr_is_coeff || wr_is_ctrl) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // The half that completes last comes straight from the bus this cycle.
   assign eff_addr = (wr_state == WR_HAVE_ADDR) ? aw_q     : s_axi_awaddr;
   assign eff_data = (wr_state == WR_HAVE_DATA) ? w_data_q : s_axi_wdata;
   assign eff_strb = (wr_state == WR_HAVE_DATA) ? w_strb_q : s_axi_wstrb;

   assign wr_word     = eff_addr[ADDR_BITS-1:2];
   assign wr_is_coeff = int'(wr_word) < NCOEF;
   assign wr_is_ctrl  = int'(wr_word) == CTRL_WORD;
   assign commit_set  = wr_fire & wr_is_ctrl & eff_strb[0] & eff_data[CTRL_COMMIT_BIT];
   assign imm_set     = commit_set & eff_data[CTRL_IMM_BIT];

   // ---------------- read FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_state <= RD_IDLE;
      else      rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE:  if (ar_hs)        rd_next = RD_VALID;
         RD_VALID: if (s_axi_rready) rd_next = RD_IDLE;
         default:                    rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      s_axi_arready = out_en & (rd_state == RD_IDLE);
      s_axi_rvalid  = (rd_state == RD_VALID);
   end

   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;
   assign dbg_rd_state = rd_state;

   assign rd_word      = s_axi_araddr[ADDR_BITS-1:2];
   assign rd_is_coeff  = int'(rd_word) < NCOEF;
   assign rd_is_ctrl   = int'(rd_word) == CTRL_WORD;
   assign rd_is_status = int'(rd_word) == STATUS_WORD;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rresp_q <= RESP_OKAY;
         if (rd_is_coeff)       rdata_q <= coeff_rd;
         else if (rd_is_status) rdata_q <= make_status(commit_pending, swap_count);
         else if (rd_is_ctrl)   rdata_q <= '0;
         else begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
         end
      end
   end

   coeff_bank_regs #(
      .KSIZE (KSIZE),
      .CW    (CW),
      .WW    (WW)
   ) u_regs (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_fire & wr_is_coeff),
      .wr_idx         (wr_word),
      .wr_data        (eff_data),
      .wr_strb        (eff_strb),
      .commit_set     (commit_set),
      .imm_set        (imm_set),
      .frame_start    (frame_start),
      .rd_idx         (rd_word),
      .rd_val         (coeff_rd),
      .coeff          (coeff),
      .coeff_update   (coeff_update),
      .commit_pending (commit_pending),
      .swap_count     (swap_count)
   );

endmodule

// File: tb/tb_axi_coeff_bank.sv
// Directed bench for axi_coeff_bank with default parameters
// (KSIZE=5, CW=16, ADDR_BITS=8): table of write/read-back vectors followed
// by hand-written sequences for swaps, channel ordering and reset.
module tb_axi_coeff_bank;

   localparam int          CWB    = 16;
   localparam int          FLATW  = 25 * CWB;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;
   localparam logic [7:0]  A_CTRL = 8'hF8;
   localparam logic [7:0]  A_STAT = 8'hFC;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       awaddr = '0;
   logic             awvalid = 1'b0;
   logic             awready;
   logic [31:0]      wdata = '0;
   logic [3:0]       wstrb = '0;
   logic             wvalid = 1'b0;
   logic             wready;
   logic [1:0]       bresp;
   logic             bvalid;
   logic             bready = 1'b0;
   logic [7:0]       araddr = '0;
   logic             arvalid = 1'b0;
   logic             arready;
   logic [31:0]      rdata;
   logic [1:0]       rresp;
   logic             rvalid;
   logic             rready = 1'b0;
   logic             frame_start = 1'b0;
   logic [FLATW-1:0] coeff;
   logic             coeff_update;
   logic [1:0]       dbg_wr_state;
   logic             dbg_rd_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_coeff_bank dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .frame_start   (frame_start),
      .coeff         (coeff),
      .coeff_update  (coeff_update),
      .dbg_wr_state  (dbg_wr_state),
      .dbg_rd_state  (dbg_rd_state)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_bresp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slice(input int k);
      return 32'(coeff[k*CWB +: CWB]);
   endfunction

   // All tasks start and end #1 after a rising edge.
   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      logic aw_done, w_done, aw_go, w_go;
      int n;
      aw_done = 1'b0; w_done = 1'b0; n = 0; resp = 2'b11;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 50) begin
         aw_go = awvalid & awready;
         w_go  = wvalid & wready;
         @(posedge clk); #1;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_go)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_done && w_done)) chk("wr_handshake_timeout", {31'b0, aw_done & w_done}, 32'd1);
      bready = 1'b1; n = 0;
      while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (bvalid) resp = bresp;
      else chk("bvalid_timeout", {31'b0, bvalid}, 32'd1);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      logic go;
      int n;
      d = '0; r = 2'b11; go = 1'b0; n = 0;
      araddr = a; arvalid = 1'b1;
      while (!go && n < 50) begin
         go = arready;
         @(posedge clk); #1;
         n++;
      end
      arvalid = 1'b0;
      if (!go) chk("ar_timeout", {31'b0, go}, 32'd1);
      rready = 1'b1; n = 0;
      while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (rvalid) begin d = rdata; r = rresp; end
      else chk("rvalid_timeout", {31'b0, rvalid}, 32'd1);
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic pulse_frame(output int pulses);
      frame_start = 1'b1; pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         frame_start = 1'b0;
         pulses += int'(coeff_update);
      end
   endtask

   task automatic idle_cycles(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         pulses += int'(coeff_update);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [1:0]  rr;
      logic [31:0] rd;
      int          cnt;

      vecs[0] = '{8'h00, 32'h0000FFFF, 4'hF, OKAY,   32'hFFFFFFFF, OKAY};
      vecs[1] = '{8'h04, 32'h00001234, 4'hF, OKAY,   32'h00001234, OKAY};
      vecs[2] = '{8'h08, 32'hABCD7FFF, 4'h1, OKAY,   32'h000000FF, OKAY};
      vecs[3] = '{8'h08, 32'h00008000, 4'h2, OKAY,   32'hFFFF80FF, OKAY};
      vecs[4] = '{8'h60, 32'h00007FFF, 4'hF, OKAY,   32'h00007FFF, OKAY};
      vecs[5] = '{8'hA0, 32'h00005555, 4'hF, SLVERR, 32'h00000000, SLVERR};
      vecs[6] = '{A_STAT, 32'h00000001, 4'hF, SLVERR, 32'h00000000, OKAY};
      vecs[7] = '{8'h64, 32'h0000AAAA, 4'hF, SLVERR, 32'h00000000, SLVERR};
      vecs[8] = '{8'h18, 32'h00001234, 4'hF, OKAY,   32'h00001234, OKAY};
      vecs[9] = '{8'h0C, 32'hFFFF0000, 4'hC, OKAY,   32'h00000000, OKAY};

      // ---- reset ----
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
      chk("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
      chk("rst_coeff_zero", {31'b0, |coeff}, 32'd0);
      chk("rst_update", {31'b0, coeff_update}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_readies", {29'b0, awready, wready, arready}, 32'd7);

      // ---- table of write / read-back vectors ----
      for (int i = 0; i < 10; i++) begin
         axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
         chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_bresp});
         axi_read(vecs[i].addr, rd, rr);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_rresp", i), {30'b0, rr}, {30'b0, vecs[i].exp_rresp});
      end
      chk("active_untouched", {31'b0, |coeff}, 32'd0);

      // ---- deferred commit on frame_start ----
      axi_write(A_CTRL, 32'h1, 4'hF, resp);
      chk("ctrl1_bresp", {30'b0, resp}, 32'd0);
      axi_read(A_STAT, rd, rr);
      chk("status_pending", rd, 32'h00000001);
      idle_cycles(3, cnt);
      chk("no_swap_without_frame", {31'b0, |coeff}, 32'd0);
      pulse_frame(cnt);
      chk("frame_pulses", cnt, 1);
      chk("slice6", slice(6), 32'h1234);
      chk("slice0", slice(0), 32'hFFFF);
      chk("slice2", slice(2), 32'h80FF);
      axi_read(A_STAT, rd, rr);
      chk("status_after_swap1", rd, 32'h00000100);

      // ---- shadow write in the swap cycle ----
      axi_write(A_CTRL, 32'h1, 4'hF, resp);
      axi_read(A_STAT, rd, rr);
      chk("status_pending2", rd, 32'h00000101);
      awaddr = 8'h10; wdata = 32'h0111; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; frame_start = 1'b1;
      chk("idle_ready_pair", {30'b0, awready, wready}, 32'd3);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
      chk("swap_prewrite_slice4", slice(4), 32'h0);
      chk("swap_prewrite_update", {31'b0, coeff_update}, 32'd1);
      chk("swap_prewrite_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("swap_prewrite_bdone", {31'b0, bvalid}, 32'd0);
      axi_read(8'h10, rd, rr);
      chk("shadow4", rd, 32'h00000111);
      axi_read(A_STAT, rd, rr);
      chk("status_after_swap2", rd, 32'h00000200);

      // ---- CTRL write coinciding with frame_start waits ----
      axi_write(8'h04, 32'h0042, 4'hF, resp);
      awaddr = A_CTRL; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; frame_start = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; frame_start = 1'b0;
      chk("coincide_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      idle_cycles(3, cnt);
      chk("coincide_no_pulse", cnt, 0);
      chk("coincide_slice1_old", slice(1), 32'h1234);
      axi_read(A_STAT, rd, rr);
      chk("coincide_status", rd, 32'h00000201);
      pulse_frame(cnt);
      chk("coincide_frame_pulses", cnt, 1);
      chk("coincide_slice1_new", slice(1), 32'h0042);
      chk("coincide_slice4_new", slice(4), 32'h0111);
      axi_read(A_STAT, rd, rr);
      chk("status_after_swap3", rd, 32'h00000300);

      // ---- immediate swap ----
      axi_write(8'h04, 32'h0077, 4'hF, resp);
      awaddr = A_CTRL; wdata = 32'h3; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("imm_bvalid", {31'b0, bvalid}, 32'd1);
      chk("imm_not_yet", slice(1), 32'h0042);
      chk("imm_update_not_yet", {31'b0, coeff_update}, 32'd0);
      @(posedge clk); #1;
      chk("imm_swapped", slice(1), 32'h0077);
      chk("imm_update", {31'b0, coeff_update}, 32'd1);
      @(posedge clk); #1;
      bready = 1'b0;
      chk("imm_update_drop", {31'b0, coeff_update}, 32'd0);
      axi_read(A_STAT, rd, rr);
      chk("status_after_imm", rd, 32'h00000400);

      // ---- W two cycles before AW, bready held low ----
      awaddr = 8'h14; wdata = 32'h0055; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      chk("wfirst_wready_low", {31'b0, wready}, 32'd0);
      chk("wfirst_awready_high", {31'b0, awready}, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cnt += int'(bvalid);
         chk($sformatf("wfirst_bresp%0d", i), {30'b0, bresp}, 32'd0);
         @(posedge clk); #1;
      end
      chk("wfirst_bvalid_held", cnt, 3);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      chk("wfirst_bvalid_drop", {31'b0, bvalid}, 32'd0);
      chk("wfirst_idle_readies", {30'b0, awready, wready}, 32'd3);
      axi_read(8'h14, rd, rr);
      chk("wfirst_data", rd, 32'h00000055);

      // ---- reset during HAVE_ADDR ----
      awaddr = 8'h1C; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      chk("mid_have_addr", {30'b0, dbg_wr_state}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_readies", {29'b0, awready, wready, arready}, 32'd0);
      chk("mid_rst_bvalid", {31'b0, bvalid}, 32'd0);
      chk("mid_rst_coeff", {31'b0, |coeff}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_release", {29'b0, awready, wready, arready}, 32'd7);
      chk("mid_rst_state", {30'b0, dbg_wr_state}, 32'd0);
      idle_cycles(2, cnt);
      chk("mid_rst_no_bvalid", {31'b0, bvalid}, 32'd0);
      axi_read(A_STAT, rd, rr);
      chk("mid_rst_status", rd, 32'h0);
      axi_read(8'h00, rd, rr);
      chk("mid_rst_shadow0", rd, 32'h0);
      axi_write(8'h1C, 32'h0099, 4'hF, resp);
      chk("post_rst_bresp", {30'b0, resp}, 32'd0);
      axi_read(8'h1C, rd, rr);
      chk("post_rst_data", rd, 32'h00000099);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
